rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
Shares one single-port memory between the fetch stage (instruction reads) and the memory stage (loads/stores driven by MemEnable/MemWrite). Only one memory transaction is outstanding at a time. Data accesses win arbitration, with a bounded starvation guard for fetch. Per-requester stall signals hold the pipeline until each access completes.

Parameters:
STARVE_MAX, 4, max consecutive data grants while fetch is pending before fetch is forced to win (range 1..15)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_valid
if_addr  in  32  fetch word address
if_rdata  out  32  fetched instruction, valid when if_valid
if_valid  out  1  one-cycle completion pulse for fetch
if_stall  out  1  if_req & ~if_valid
d_req  in  1  data request (MemEnable); held with d_* stable until d_valid
d_we  in  1  1 = store (MemWrite), 0 = load
d_addr  in  32  data address (ALU result)
d_wdata  in  32  store data
d_be  in  4  byte enables
d_rdata  out  32  load data, valid when d_valid
d_valid  out  1  one-cycle completion pulse for load or store
d_stall  out  1  d_req & ~d_valid
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  write strobe
mem_addr  out  32  address
mem_wdata  out  32  write data
mem_be  out  4  byte enables (4'b1111 for fetch)
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  read data returned this cycle
mem_rdata  in  32  read data

Behaviour:
- States: IDLE, REQ, RESP. Owner register: 0 = IF, 1 = D.
- Reset: state IDLE; mem_req, mem_we, if_valid, d_valid = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; mem_be = 0; starve_cnt = 0; owner = 0.
- IDLE, arbitration:
  - If d_req and (~if_req or starve_cnt < STARVE_MAX): owner = D.
  - Else if if_req: owner = IF.
  - Register mem_req = 1 with the owner's addr/we/wdata/be. Fetch uses we = 0, be = 4'b1111.
  - Go to REQ. No request: stay in IDLE.
- REQ: mem_req and all mem_* fields held constant until mem_gnt.
  - gnt & write: mem_req = 0, pulse d_valid next cycle, go to IDLE.
  - gnt & read & mem_rvalid in the same cycle: capture mem_rdata, pulse owner's valid next cycle, go to IDLE.
  - gnt & read otherwise: mem_req = 0, go to RESP.
- RESP: wait for mem_rvalid, then capture mem_rdata into if_rdata or d_rdata, pulse owner's valid next cycle, go to IDLE.
- Latency (request sampled in IDLE at cycle 0):
  - mem_req at cycle 1.
  - gnt at 1, rvalid at 2: valid at cycle 3.
  - gnt + rvalid at 1: valid at cycle 2.
  - Write with gnt at 1: d_valid at cycle 2.
- Back-to-back: the valid pulse cycle coincides with IDLE. The requester drops or changes its request in that same cycle, so IDLE arbitration that cycle uses the updated inputs.
- rdata outputs hold their last captured value until the next capture.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each D grant issued while if_req = 1.
  - Clears on an IF grant, or in any IDLE cycle with if_req = 0.
  - Both requesting with starve_cnt == STARVE_MAX: IF wins.
- mem_rvalid in IDLE, or in REQ without mem_gnt: ignored (covers stale responses after reset).
- mem_gnt outside REQ: ignored.
- Stalls are combinational from req/valid. Other outputs are registered.
- Async reset mid-transaction: immediate return to IDLE, mem_req = 0, no valid pulse. The requester re-issues.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x100; gnt at cycle 1, rvalid with 0x00500093 at cycle 2 -> if_valid and if_rdata = 0x00500093 at cycle 3; if_stall high in cycles 0-2.
- Contention: if_req and d_req (load, 0x2000) raised together -> D owns the first transaction; IF is issued in the IDLE cycle after d_valid; if_stall stays high throughout.
- Store: d_we = 1, d_addr = 0x2004, d_wdata = 0xDEADBEEF, d_be = 4'b0011, gnt delayed 3 cycles -> mem_* held stable during the wait; d_valid exactly 1 cycle after gnt; no rvalid needed.
- Starvation (STARVE_MAX = 4): if_req and d_req held continuously -> grants D, D, D, D, IF, then D resumes.
- Same-cycle gnt + rvalid for a load of 0x12345678 -> d_valid at cycle 2; RESP never entered.
- Reset: rst_n low during RESP, released, then a stale mem_rvalid -> no valid pulse, state IDLE, mem_req = 0.

Source files
------------

// File: rtl/rv32i_mem_arbiter_if.sv
// Signal bundle between the fetch stage, the memory stage, the arbiter and a
// single-port memory. The arbiter connects through the master modport.
interface rv32i_mem_arbiter_if;
  // Handshakes: a requester holds its req and payload stable until its
  // one-cycle valid pulse. mem_req and mem_* are held until mem_gnt, and read
  // data is taken only in the cycle mem_rvalid is high.
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_valid, if_stall,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_rdata, d_valid, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_valid, if_stall,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_rdata, d_valid, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data accesses.
// Data wins arbitration unless fetch has been passed over STARVE_MAX times.
module rv32i_mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rv32i_mem_arbiter_if.master  bus,
  output logic [1:0]           dbg_state,
  output logic                 dbg_owner,
  output logic [3:0]           dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic       owner;        // 0 = fetch, 1 = data
  logic [3:0] starve_cnt;
  logic       d_win;
  logic [3:0] starve_inc;

  // Fetch is only forced through once data has been granted STARVE_MAX times
  // in a row while fetch was waiting.
  assign d_win      = bus.d_req && (!bus.if_req || (starve_cnt < STARVE_LIM));
  assign starve_inc = (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;

  assign bus.if_stall = bus.if_req & ~bus.if_valid;
  assign bus.d_stall  = bus.d_req  & ~bus.d_valid;

  assign dbg_state      = state;
  assign dbg_owner      = owner;
  assign dbg_starve_cnt = starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= 1'b0;
      starve_cnt    <= 4'd0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.mem_be    <= 4'd0;
      bus.if_valid  <= 1'b0;
      bus.d_valid   <= 1'b0;
      bus.if_rdata  <= 32'd0;
      bus.d_rdata   <= 32'd0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_win) begin
            owner         <= 1'b1;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_be    <= bus.d_be;
            starve_cnt    <= bus.if_req ? starve_inc : 4'd0;
            state         <= REQ;
          end else if (bus.if_req) begin
            owner         <= 1'b0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= 32'd0;
            bus.mem_be    <= 4'b1111;
            starve_cnt    <= 4'd0;
            state         <= REQ;
          end else begin
            starve_cnt <= 4'd0;
          end
        end

        REQ: begin
          // Responses without a grant are stale and are dropped.
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            if (bus.mem_we) begin
              bus.d_valid <= 1'b1;
              state       <= IDLE;
            end else if (bus.mem_rvalid) begin
              if (owner) begin
                bus.d_rdata <= bus.mem_rdata;
                bus.d_valid <= 1'b1;
              end else begin
                bus.if_rdata <= bus.mem_rdata;
                bus.if_valid <= 1'b1;
              end
              state <= IDLE;
            end else begin
              state <= RESP;
            end
          end
        end

        RESP: begin
          if (bus.mem_rvalid) begin
            if (owner) begin
              bus.d_rdata <= bus.mem_rdata;
              bus.d_valid <= 1'b1;
            end else begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end

        default: begin
          bus.mem_req <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: fetch, contention, store, starvation,
// same-cycle response and mid-transaction reset.
module tb_rv32i_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic       dbg_owner;
  logic [3:0] dbg_starve_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  rv32i_mem_arbiter_if bus ();

  rv32i_mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_owner      (dbg_owner),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for mem_req, starting in the current cycle.
  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req === 1'b1) return;
      tick();
    end
    check("mem_req_timeout", 32'd0, 32'd1);
  endtask

  // Called in a cycle where mem_req should be visible. Holds off the grant
  // for gnt_wait cycles, then returns read data rv_wait cycles after the
  // grant (0 = same cycle). Returns in the cycle the valid pulse is due.
  task automatic serve(input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                       input logic [31:0] e_addr, input logic e_we,
                       input logic [31:0] e_wdata, input logic [3:0] e_be);
    for (int i = 0; i <= gnt_wait; i++) begin
      check("mem_req_held", bus.mem_req, 1);
      check("mem_addr", bus.mem_addr, e_addr);
      check("mem_we", bus.mem_we, e_we);
      check("mem_be", bus.mem_be, e_be);
      if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
      if (i < gnt_wait) tick();
    end
    bus.mem_gnt = 1'b1;
    if (!e_we && rv_wait == 0) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
    end
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    if (!e_we && rv_wait > 0) begin
      for (int i = 1; i < rv_wait; i++) begin
        check("resp_wait_no_valid", bus.if_valid | bus.d_valid, 0);
        tick();
      end
      check("resp_mem_req_low", bus.mem_req, 0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      tick();
      bus.mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    int         cnt_exp[6];
    logic [31:0] e;

    cnt_exp = '{1, 2, 3, 4, 0, 1};
    rst_n = 1'b0;
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    repeat (3) tick();

    // reset state
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_be", bus.mem_be, 0);
    check("rst_valids", {bus.if_valid, bus.d_valid}, 0);
    check("rst_rdata", bus.if_rdata | bus.d_rdata, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // fetch only: valid at cycle 3
    bus.if_req = 1; bus.if_addr = 32'h100;
    #1 check("f_stall_c0", bus.if_stall, 1);
    tick();
    serve(0, 1, 32'h00500093, 32'h100, 0, 0, 4'hF);
    check("f_if_valid_c3", bus.if_valid, 1);
    check("f_if_rdata", bus.if_rdata, 32'h00500093);
    check("f_stall_c3", bus.if_stall, 0);
    bus.if_req = 0;
    tick();
    check("f_if_valid_pulse", bus.if_valid, 0);
    check("f_idle", dbg_state, 0);

    // contention: data first, fetch issued in the idle cycle after d_valid
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000; bus.d_be = 4'hF;
    tick();
    check("c_owner_d", dbg_owner, 1);
    serve(0, 1, 32'hCAFEF00D, 32'h2000, 0, 0, 4'hF);
    check("c_d_valid", bus.d_valid, 1);
    check("c_d_rdata", bus.d_rdata, 32'hCAFEF00D);
    check("c_if_stall", bus.if_stall, 1);
    bus.d_req = 0;
    tick();
    check("c_if_stall2", bus.if_stall, 1);
    serve(0, 1, 32'h00000013, 32'h104, 0, 0, 4'hF);
    check("c_if_valid", bus.if_valid, 1);
    check("c_if_rdata", bus.if_rdata, 32'h00000013);
    bus.if_req = 0;
    tick();

    // store with grant delayed 3 cycles
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'b0011;
    #1 check("s_d_stall", bus.d_stall, 1);
    tick();
    serve(3, 0, 32'h0, 32'h2004, 1, 32'hDEADBEEF, 4'b0011);
    check("s_d_valid", bus.d_valid, 1);
    check("s_mem_req_low", bus.mem_req, 0);
    check("s_d_stall_low", bus.d_stall, 0);
    check("s_d_rdata_hold", bus.d_rdata, 32'hCAFEF00D);
    bus.d_req = 0; bus.d_we = 0;
    tick();
    check("s_d_valid_pulse", bus.d_valid, 0);

    // starvation: D D D D IF D with both held
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h3000);
    exp_q.push_back(32'h400);
    exp_q.push_back(32'h3000);
    bus.if_req = 1; bus.if_addr = 32'h400;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3000; bus.d_be = 4'hF;
    for (int k = 0; k < 6; k++) begin
      wait_req();
      e = exp_q.pop_front();
      check("sv_starve_cnt", dbg_starve_cnt, cnt_exp[k]);
      serve(0, 0, e + k, e, 0, 0, 4'hF);
      if (e == 32'h400) begin
        check("sv_if_valid", bus.if_valid, 1);
        check("sv_if_rdata", bus.if_rdata, e + k);
      end else begin
        check("sv_d_valid", bus.d_valid, 1);
        check("sv_d_rdata", bus.d_rdata, e + k);
      end
    end
    bus.if_req = 0; bus.d_req = 0;
    tick();

    // same-cycle grant + rvalid
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2008; bus.d_be = 4'hF;
    tick();
    check("sc_state_req", dbg_state, 1);
    serve(0, 0, 32'h12345678, 32'h2008, 0, 0, 4'hF);
    check("sc_d_valid_c2", bus.d_valid, 1);
    check("sc_d_rdata", bus.d_rdata, 32'h12345678);
    check("sc_no_resp", dbg_state, 0);
    bus.d_req = 0;
    tick();

    // reset during RESP, then a stale rvalid
    bus.if_req = 1; bus.if_addr = 32'h200;
    tick();
    bus.mem_gnt = 1;
    tick();
    bus.mem_gnt = 0;
    check("r_in_resp", dbg_state, 2);
    rst_n = 1'b0;
    #1;
    check("r_async_mem_req", bus.mem_req, 0);
    check("r_async_state", dbg_state, 0);
    bus.if_req = 0;
    tick();
    rst_n = 1'b1;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0BAD0;
    tick();
    bus.mem_rvalid = 0;
    check("r_stale_no_valid", {bus.if_valid, bus.d_valid}, 0);
    check("r_if_rdata", bus.if_rdata, 0);
    check("r_state", dbg_state, 0);
    check("r_mem_req", bus.mem_req, 0);
    tick();
    check("r_still_no_valid", {bus.if_valid, bus.d_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
